// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared instruction/data memory, one word per three-state access.
// Define ARB_FIXED_PRIO_EN for fixed priority (m0 wins ties); otherwise ties are round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_Write_data,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_Mem_data,
  output logic              owner,
  output logic              busy,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Handshake: a requester raises req with we/addr/wdata and holds it until its
  // ready pulses for one cycle; inputs are only sampled on the grant edge.

  state_t              state;
  state_t              state_next;
  logic                any_req;
  logic                winner;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;

  assign any_req   = m0_req | m1_req;
  assign dbg_state = state;

  always_comb begin
    winner = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    winner = ~m0_req;
`else
    if (m0_req && m1_req) winner = ~owner;
    else                  winner = m1_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Grant latch, read capture and saturating grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner     <= winner;
            lat_we    <= winner ? m1_we    : m0_we;
            lat_addr  <= winner ? m1_addr  : m0_addr;
            lat_wdata <= winner ? m1_wdata : m0_wdata;
          end
        end
        ST_ACCESS: begin
          if (!lat_we) rdata_q <= mem_Mem_data;
        end
        ST_DONE: begin
          if (!owner && (gnt_cnt0 != {CNT_W{1'b1}})) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
          if (owner && (gnt_cnt1 != {CNT_W{1'b1}}))  gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_Address    = '0;
    mem_Write_data = '0;
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    m0_ready       = 1'b0;
    m1_ready       = 1'b0;
    m0_rdata       = '0;
    m1_rdata       = '0;
    busy           = (state == ST_ACCESS) || (state == ST_DONE);
    case (state)
      ST_ACCESS: begin
        mem_Address = lat_addr;
        if (lat_we) begin
          mem_MemWrite   = 1'b1;
          mem_Write_data = lat_wdata;
        end else begin
          mem_MemRead = 1'b1;
        end
      end
      ST_DONE: begin
        if (owner) begin
          m1_ready = 1'b1;
          m1_rdata = lat_we ? '0 : rdata_q;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = lat_we ? '0 : rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-master traffic checked
// against a word-array memory model and arbitration rules.
module tb_mem_arbiter;

  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_rst = 1'b1;
  logic              m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0]       m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic              m0_ready, m1_ready;
  logic [31:0]       m0_rdata, m1_rdata;
  logic [31:0]       mem_Address, mem_Write_data, mem_Mem_data;
  logic              mem_MemRead, mem_MemWrite;
  logic              owner, busy;
  logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad = 0;
  int wr_cycles = 0;
  logic [31:0] tb_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_Address(mem_Address), .mem_Write_data(mem_Write_data),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_Mem_data(mem_Mem_data),
    .owner(owner), .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h3c04abcd;
    if (i == 1) return 32'h20841234;
    if (i == 2) return 32'h8c220008;
    return (32'h01010101 * i) ^ 32'ha5a50000;
  endfunction

  // unified memory: combinational read, write on the closing edge of MemWrite
  assign mem_Mem_data = tb_mem[mem_Address[9:2]];
  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
    end else if (mem_MemWrite) begin
      tb_mem[mem_Address[9:2]] <= mem_Write_data;
    end
  end

  always @(negedge clk) if (mem_MemWrite) wr_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; mem_rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    @(posedge clk); #1;
    reset = 1'b0; mem_rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  // driver: one access on master m, held until its ready, with scoreboard checks
  task automatic do_access(input int m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output int lat);
    logic seen;
    @(posedge clk); #1;
    if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    else        begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    lat = 0; seen = 0; rdata = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if ((m == 0) ? m0_ready : m1_ready) begin
        seen = 1;
        rdata = (m == 0) ? m0_rdata : m1_rdata;
        check("other_ready", (m == 0) ? {31'd0, m1_ready} : {31'd0, m0_ready}, 0);
        check("other_rdata", (m == 0) ? m1_rdata : m0_rdata, 0);
        if (we) ref_mem[addr[9:2]] = wdata;
        else    check("rdata", rdata, ref_mem[addr[9:2]]);
      end
    end
    check("timeout", {31'd0, seen}, 1);
    if (seen && !(FIXED && m == 1)) check("latency_bound", {31'd0, lat <= 6}, 1);
    @(posedge clk); #1;
    if (m == 0) m0_req = 0; else m1_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    int w0;
    int n0, n1, cyc, readies;
    int rdy_cyc [$];
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_owner", {31'd0, owner}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {30'd0, m0_ready, m1_ready}, 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    check("rst_memctl", {30'd0, mem_MemRead, mem_MemWrite}, 0);
    check("rst_addr", mem_Address, 0);
    check("rst_cnt", {26'd0, gnt_cnt0, gnt_cnt1}, 0);

    // single read from m0, cycle by cycle
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h4;
    @(negedge clk);
    check("sr_c1_memread", {31'd0, mem_MemRead}, 0);
    @(negedge clk);
    check("sr_c2_memread", {31'd0, mem_MemRead}, 1);
    check("sr_c2_addr", mem_Address, 32'h4);
    check("sr_c2_busy", {31'd0, busy}, 1);
    @(negedge clk);
    check("sr_c3_ready", {31'd0, m0_ready}, 1);
    check("sr_c3_rdata", m0_rdata, 32'h20841234);
    check("sr_c3_memread", {31'd0, mem_MemRead}, 0);
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    check("sr_cnt0", {29'd0, gnt_cnt0}, 1);
    check("sr_owner", {31'd0, owner}, 0);
    check("sr_ready_gone", {31'd0, m0_ready}, 0);

    // m1 write then read back
    w0 = wr_cycles;
    do_access(1, 1'b1, 32'h200, 32'hdeadbeef, rd, lat);
    check("wr_latency", lat, 3);
    check("wr_memwrite_cycles", wr_cycles - w0, 1);
    do_access(1, 1'b0, 32'h200, 32'h0, rd, lat);
    check("rb_data", rd, 32'hdeadbeef);
    check("rb_latency", lat, 3);
    check("rb_cnt1", {29'd0, gnt_cnt1}, 2);

    // inputs changed after the grant are ignored
    do_reset();
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0;
    @(posedge clk); #1;
    m0_addr = 32'h8; m0_we = 1; m0_wdata = $urandom();
    @(negedge clk);
    check("chg_addr", mem_Address, 32'h0);
    check("chg_memread", {30'd0, mem_MemRead, mem_MemWrite}, 2'b10);
    @(negedge clk);
    check("chg_rdata", m0_rdata, 32'h3c04abcd);
    @(posedge clk); #1;
    m0_req = 0; m0_we = 0;

    // contention: both hold req for four accesses
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(FIXED ? 32'd0 : 32'(i % 2));
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h4;
    cyc = 0; readies = 0;
    rdy_cyc.delete();
    while (readies < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m0_ready || m1_ready) begin
        readies++;
        rdy_cyc.push_back(cyc);
        if (exp_q.size() > 0) check("ct_order", {31'd0, m1_ready}, exp_q.pop_front());
        check("ct_rdata", m1_ready ? m1_rdata : m0_rdata, m1_ready ? 32'h20841234 : 32'h3c04abcd);
      end
    end
    m0_req = 0; m1_req = 0;
    check("ct_readies", readies, 4);
    for (int i = 0; i < rdy_cyc.size(); i++) check("ct_spacing", rdy_cyc[i], 3 * (i + 1));
    @(negedge clk);
    check("ct_cnt0", {29'd0, gnt_cnt0}, FIXED ? 32'd4 : 32'd2);
    check("ct_cnt1", {29'd0, gnt_cnt1}, FIXED ? 32'd0 : 32'd2);

    // reset during ACCESS of an m0 read
    do_reset();
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h4;
    @(negedge clk);
    @(negedge clk);
    check("ra_in_access", {30'd0, busy, mem_MemRead}, 2'b11);
    reset = 1; m0_req = 0;
    @(negedge clk);
    check("ra_busy", {31'd0, busy}, 0);
    check("ra_memctl", {30'd0, mem_MemRead, mem_MemWrite}, 0);
    check("ra_addr", mem_Address, 0);
    check("ra_owner", {31'd0, owner}, 1);
    check("ra_cnt", {26'd0, gnt_cnt0, gnt_cnt1}, 0);
    reset = 0;
    readies = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) readies++;
    end
    check("ra_no_ready", readies, 0);

    // reset and req together: reset wins
    reset = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h8;
    @(negedge clk);
    check("rr_busy", {31'd0, busy}, 0);
    check("rr_owner", {31'd0, owner}, 1);
    reset = 0; m1_req = 0;
    @(negedge clk);
    check("rr_idle", {31'd0, busy}, 0);

    // counter saturation
    do_reset();
    for (int i = 0; i < CMAX + 2; i++) do_access(0, 1'b0, 32'h8, 32'h0, rd, lat);
    check("sat_cnt0", {29'd0, gnt_cnt0}, CMAX);
    check("sat_cnt1", {29'd0, gnt_cnt1}, 0);

    // random traffic from both masters
    do_reset();
    n0 = 0; n1 = 0;
    fork
      begin
        logic [31:0] r0;
        int l0;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_access(0, 1'($urandom_range(0, 1)), $urandom() & 32'hfffffc3f,
                    $urandom(), r0, l0);
          n0++;
        end
      end
      begin
        logic [31:0] r1;
        int l1;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_access(1, 1'($urandom_range(0, 1)), $urandom() & 32'hfffffc3f,
                    $urandom(), r1, l1);
          n1++;
        end
      end
    join
    @(negedge clk);
    check("rnd_cnt0", {29'd0, gnt_cnt0}, (n0 > CMAX) ? CMAX : n0);
    check("rnd_cnt1", {29'd0, gnt_cnt1}, (n1 > CMAX) ? CMAX : n1);
    check("rnd_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
